// File: rtl/mem_seq.sv
// LC-3 memory-access sequencer: steps one LD/LDR/LDI/ST/STR/STI through
// indirect-read, read and write phases and returns load results to writeback.
module mem_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [2:0]  ex_dr,
  input  logic [15:0] ex_addr,
  input  logic [15:0] ex_data,
  input  logic [15:0] dmem_dout,
  output logic [1:0]  mem_state,
  output logic [15:0] M_Addr,
  output logic [15:0] M_Data,
  output logic        M_Control,
  output logic        stall,
  output logic        wb_load,
  output logic [2:0]  wb_dr,
  output logic [15:0] wb_data
);

  typedef enum logic [1:0] {
    IND  = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    IDLE = 2'd3
  } state_t;

  state_t      state;
  logic        store_q;
  logic [15:0] data_q;
  logic [2:0]  dr_q;

  logic        is_load;
  logic        is_store;
  logic        is_ind;
  logic        accept;

  always_comb begin
    is_load  = (ex_opcode == 4'b0010) || (ex_opcode == 4'b0110) || (ex_opcode == 4'b1010);
    is_store = (ex_opcode == 4'b0011) || (ex_opcode == 4'b0111) || (ex_opcode == 4'b1011);
    is_ind   = (ex_opcode == 4'b1010) || (ex_opcode == 4'b1011);
    accept   = ex_valid && (is_load || is_store);
  end

  // M_Addr/M_Data/M_Control are registered with the state; after IND,
  // M_Addr itself holds the fetched pointer for the RD/WR phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      store_q   <= 1'b0;
      data_q    <= 16'h0000;
      dr_q      <= 3'd0;
      M_Addr    <= 16'h0000;
      M_Data    <= 16'h0000;
      M_Control <= 1'b0;
      wb_load   <= 1'b0;
      wb_dr     <= 3'd0;
      wb_data   <= 16'h0000;
    end else begin
      wb_load <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            store_q   <= is_store;
            data_q    <= ex_data;
            dr_q      <= ex_dr;
            M_Addr    <= ex_addr;
            M_Control <= 1'b0;
            if (is_ind) begin
              state  <= IND;
              M_Data <= 16'h0000;
            end else if (is_store) begin
              state  <= WR;
              M_Data <= ex_data;
            end else begin
              state  <= RD;
              M_Data <= 16'h0000;
            end
          end
        end
        IND: begin
          M_Addr    <= dmem_dout;
          M_Control <= 1'b1;
          if (store_q) begin
            state  <= WR;
            M_Data <= data_q;
          end else begin
            state  <= RD;
            M_Data <= 16'h0000;
          end
        end
        RD: begin
          wb_data   <= dmem_dout;
          wb_dr     <= dr_q;
          wb_load   <= 1'b1;
          state     <= IDLE;
          M_Addr    <= 16'h0000;
          M_Data    <= 16'h0000;
          M_Control <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          M_Addr    <= 16'h0000;
          M_Data    <= 16'h0000;
          M_Control <= 1'b0;
        end
      endcase
    end
  end

  assign mem_state = state;
  assign stall     = (state != IDLE);

endmodule

// File: tb/tb_mem_seq.sv
// Scoreboard bench for mem_seq: a behavioural data memory answers reads and
// records writes; expected loads are queued at issue and popped on wb_load.
module tb_mem_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_dr;
  logic [15:0] ex_addr;
  logic [15:0] ex_data;
  logic [15:0] dmem_dout;
  logic [1:0]  mem_state;
  logic [15:0] M_Addr;
  logic [15:0] M_Data;
  logic        M_Control;
  logic        stall;
  logic        wb_load;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;

  logic [15:0] mem [0:65535];
  logic [18:0] sb [$];
  logic [18:0] exp_ld;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_wr  = 0;
  int          n_ld  = 0;
  int          wr0;
  int          ld0;

  always #5 clock = ~clock;

  mem_seq dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_dr(ex_dr), .ex_addr(ex_addr), .ex_data(ex_data), .dmem_dout(dmem_dout),
    .mem_state(mem_state), .M_Addr(M_Addr), .M_Data(M_Data), .M_Control(M_Control),
    .stall(stall), .wb_load(wb_load), .wb_dr(wb_dr), .wb_data(wb_data)
  );

  assign dmem_dout = mem[M_Addr];

  always @(posedge clock) begin
    if (mem_state == 2'd2) begin
      mem[M_Addr] <= M_Data;
      n_wr <= n_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (wb_load === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_ld = sb.pop_front();
        check("wb_dr", {29'd0, wb_dr}, {29'd0, exp_ld[18:16]});
        check("wb_data", {16'd0, wb_data}, {16'd0, exp_ld[15:0]});
        n_ld++;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] dr,
                       input logic [15:0] addr, input logic [15:0] data);
    ex_valid  = 1'b1;
    ex_opcode = op;
    ex_dr     = dr;
    ex_addr   = addr;
    ex_data   = data;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_state"}, {30'd0, mem_state}, 32'd3);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_wbload"}, {31'd0, wb_load}, 32'd0);
    check({tag, "_addr"}, {16'd0, M_Addr}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ex_valid = 1'b0; ex_opcode = 4'd0; ex_dr = 3'd0; ex_addr = 16'd0; ex_data = 16'd0;
    mem[16'h3010] = 16'hBEEF;
    mem[16'h3020] = 16'h4000;
    mem[16'h4000] = 16'h0000;
    mem[16'h3030] = 16'hFFFF;
    mem[16'hFFFF] = 16'h00A5;
    mem[16'h3040] = 16'h0000;
    repeat (3) tick();
    idle_checks("rst");
    check("rst_mdata", {16'd0, M_Data}, 32'd0);
    check("rst_mctl", {31'd0, M_Control}, 32'd0);
    check("rst_wbdr", {29'd0, wb_dr}, 32'd0);
    check("rst_wbdata", {16'd0, wb_data}, 32'd0);
    reset = 1'b0;
    tick();

    // LD
    drive(4'b0010, 3'd5, 16'h3010, 16'h0000);
    sb.push_back({3'd5, 16'hBEEF});
    tick(); ex_valid = 1'b0;
    check("ld_c1_state", {30'd0, mem_state}, 32'd1);
    check("ld_c1_addr", {16'd0, M_Addr}, 32'h3010);
    check("ld_c1_mctl", {31'd0, M_Control}, 32'd0);
    check("ld_c1_stall", {31'd0, stall}, 32'd1);
    tick();
    check("ld_c2_wbload", {31'd0, wb_load}, 32'd1);
    check("ld_c2_state", {30'd0, mem_state}, 32'd3);
    tick();
    check("ld_c3_wbload", {31'd0, wb_load}, 32'd0);

    // STI
    wr0 = n_wr;
    drive(4'b1011, 3'd0, 16'h3020, 16'h1234);
    tick(); ex_valid = 1'b0;
    check("sti_c1_state", {30'd0, mem_state}, 32'd0);
    check("sti_c1_addr", {16'd0, M_Addr}, 32'h3020);
    check("sti_c1_stall", {31'd0, stall}, 32'd1);
    tick();
    check("sti_c2_state", {30'd0, mem_state}, 32'd2);
    check("sti_c2_addr", {16'd0, M_Addr}, 32'h4000);
    check("sti_c2_mctl", {31'd0, M_Control}, 32'd1);
    check("sti_c2_mdata", {16'd0, M_Data}, 32'h1234);
    tick();
    idle_checks("sti_c3");
    check("sti_mem", {16'd0, mem[16'h4000]}, 32'h1234);
    check("sti_writes", n_wr - wr0, 32'd1);
    check("wb_hold", {16'd0, wb_data}, 32'hBEEF);

    // LDI through pointer 0xFFFF
    drive(4'b1010, 3'd3, 16'h3030, 16'h0000);
    sb.push_back({3'd3, 16'h00A5});
    tick(); ex_valid = 1'b0;
    check("ldi_c1_state", {30'd0, mem_state}, 32'd0);
    tick();
    check("ldi_c2_state", {30'd0, mem_state}, 32'd1);
    check("ldi_c2_addr", {16'd0, M_Addr}, 32'hFFFF);
    check("ldi_c2_mctl", {31'd0, M_Control}, 32'd1);
    check("ldi_c2_stall", {31'd0, stall}, 32'd1);
    tick();
    check("ldi_c3_wbload", {31'd0, wb_load}, 32'd1);
    check("ldi_c3_wbdata", {16'd0, wb_data}, 32'h00A5);
    tick();

    // ST then LD with ex_valid held high
    wr0 = n_wr; ld0 = n_ld;
    drive(4'b0011, 3'd0, 16'h3040, 16'h5555);
    tick();
    check("b2b_c1_state", {30'd0, mem_state}, 32'd2);
    check("b2b_c1_mdata", {16'd0, M_Data}, 32'h5555);
    drive(4'b0010, 3'd2, 16'h3010, 16'h0000);
    tick();
    check("b2b_c2_noacc", {30'd0, mem_state}, 32'd3);
    sb.push_back({3'd2, 16'hBEEF});
    tick(); ex_valid = 1'b0;
    check("b2b_c3_state", {30'd0, mem_state}, 32'd1);
    tick();
    check("b2b_c4_wbload", {31'd0, wb_load}, 32'd1);
    tick();
    check("b2b_writes", n_wr - wr0, 32'd1);
    check("b2b_loads", n_ld - ld0, 32'd1);
    check("b2b_mem", {16'd0, mem[16'h3040]}, 32'h5555);

    // non-memory opcode
    drive(4'b0001, 3'd1, 16'h3010, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_checks("add");
    end
    ex_valid = 1'b0;

    // reset held 2 cycles while in IND
    drive(4'b1010, 3'd4, 16'h3030, 16'h0000);
    tick(); ex_valid = 1'b0;
    check("rstind_pre", {30'd0, mem_state}, 32'd0);
    reset = 1'b1;
    tick();
    idle_checks("rstind_r1");
    tick();
    idle_checks("rstind_r2");
    reset = 1'b0;
    tick();
    idle_checks("rstind_post");
    check("rstind_wbdata", {16'd0, wb_data}, 32'd0);

    // reset during RD suppresses the pending wb_load
    drive(4'b0110, 3'd6, 16'h3010, 16'h0000);
    tick(); ex_valid = 1'b0;
    check("rstrd_pre", {30'd0, mem_state}, 32'd1);
    reset = 1'b1;
    tick();
    idle_checks("rstrd");
    reset = 1'b0;
    tick();
    check("rstrd_post_wbload", {31'd0, wb_load}, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
